uart_frame_sched: RTL
=====================

# uart_frame_sched

Transmit scheduler between the two 1 KB byte buffers (RX-echo buffer and TX buffer) and the UART transmitter. It collects frame-complete notifications from the buffer writers, arbitrates round-robin between the two sources, and streams each frame's bytes out of the selected buffer's read port into a valid/ready byte interface feeding the UART TX serializer. It owns both buffers' read ports; the write ports stay with the writers.

## Interface
- ADDR_W, 10, buffer address width; frame length is ADDR_W bits (1..1023 bytes).
- DATA_W, 8, byte width.
- i_clk  in  1  system clock (125 MHz domain).
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_mem_wdone  in  1  one-cycle pulse: RX buffer frame complete.
- i_rx_mem_byte  in  ADDR_W  RX frame length; sampled only with i_rx_mem_wdone.
- i_tx_mem_wdone  in  1  one-cycle pulse: TX buffer frame complete.
- i_tx_mem_byte  in  ADDR_W  TX frame length; sampled only with i_tx_mem_wdone.
- o_rx_mem_ren  out  1  RX buffer read enable.
- o_rx_mem_raddr  out  ADDR_W  RX buffer read address.
- i_rx_mem_rdata  in  DATA_W  RX buffer read data, 1-cycle latency after ren.
- o_tx_mem_ren, o_tx_mem_raddr, i_tx_mem_rdata  same as RX set, for the TX buffer.
- o_byte_valid  out  1  byte available to UART TX.
- o_byte_data  out  DATA_W  byte to send; stable while o_byte_valid.
- i_byte_ready  in  1  UART TX accepts byte.
- o_busy  out  1  frame in service (state != IDLE).
- o_src  out  1  source in service: 0 = RX buffer, 1 = TX buffer; holds last value in IDLE.
- o_frame_done  out  1  one-cycle pulse after last byte of a frame accepted.
- o_drop  out  1  one-cycle pulse: wdone rejected (source already pending).

## Operation
- Per source: pending flag + latched length. wdone with length 0: ignored, no drop. wdone with pending already set (waiting or in service): o_drop next cycle, latched length unchanged.
- Same-cycle pending clear (DONE for that source) and wdone for that source: clear wins first, new frame is accepted as pending, no drop.
- Simultaneous wdone on both sources: both accepted.
- Arbitration in IDLE: one pending -> grant it; both pending -> grant the source not served last. Last-served pointer resets to 1 (TX), so RX wins the first tie.
- FSM: IDLE -> READ (grant, idx=0) -> LAT -> HOLD -> (idx==len-1 ? DONE : READ with idx+1); DONE -> IDLE.
- READ: selected ren=1, raddr=idx, one cycle. Unselected ren=0 always.
- LAT: rdata valid; captured into o_byte_data at end of cycle.
- HOLD: o_byte_valid=1 until valid&&ready at a rising edge; then valid drops next cycle.
- DONE: o_frame_done=1, clear source pending, update last-served pointer.
- idx is ADDR_W bits, never wraps (len <= 1023).
- Reset (async, any state): state IDLE, pendings/lengths/idx 0, pointer 1, all outputs 0 (o_src 0, o_byte_data 0). Partially sent frame abandoned.

## Timing
- wdone in cycle N -> pending visible cycle N+1 -> IDLE grants, READ in N+2 -> LAT N+3 -> o_byte_valid from N+4.
- With i_byte_ready tied high: one byte every 3 cycles (READ, LAT, HOLD); frame of L bytes occupies 3L+1 cycles from READ through DONE.
- o_frame_done in the cycle after last-byte acceptance; next frame's READ no earlier than 2 cycles after DONE (IDLE, then READ).
- o_drop asserted the cycle after the rejected wdone.
- o_byte_data must not change while o_byte_valid=1 and not accepted.

## Test plan
- Single RX frame len 3, data 0x41,0x42,0x43, ready high -> raddr 0,1,2 on o_rx_mem_raddr, bytes 0x41,0x42,0x43, first valid at N+4, o_frame_done once, o_tx_mem_ren never high.
- Both wdone same cycle (RX len 2, TX len 1) after reset -> RX frame fully sent first, then TX; o_src 0 then 1; two o_frame_done pulses.
- Backpressure: ready low 10 cycles during HOLD -> o_byte_valid and o_byte_data held constant; no extra ren; resumes correctly.
- Second RX wdone (len 5) while RX frame len 4 in service -> o_drop pulse, 4 bytes sent, no further RX frame; wdone coincident with DONE -> accepted, second frame sent.
- Length 0 wdone -> no pending, no drop, o_busy stays 0; len 1023 frame -> addresses 0..1022, single frame_done.
- Assert i_reset mid-frame (in HOLD) -> all outputs 0 immediately; after release, new TX frame len 1 served normally.

Source files
------------

// File: rtl/uart_frame_sched.sv
// Round-robin transmit scheduler: drains completed frames from the RX-echo and TX
// byte buffers, one byte at a time, into the UART TX valid/ready byte stream.
module uart_frame_sched #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_mem_wdone,
   input  logic [ADDR_W-1:0] i_rx_mem_byte,
   input  logic              i_tx_mem_wdone,
   input  logic [ADDR_W-1:0] i_tx_mem_byte,
   output logic              o_rx_mem_ren,
   output logic [ADDR_W-1:0] o_rx_mem_raddr,
   input  logic [DATA_W-1:0] i_rx_mem_rdata,
   output logic              o_tx_mem_ren,
   output logic [ADDR_W-1:0] o_tx_mem_raddr,
   input  logic [DATA_W-1:0] i_tx_mem_rdata,
   output logic              o_byte_valid,
   output logic [DATA_W-1:0] o_byte_data,
   input  logic              i_byte_ready,
   output logic              o_busy,
   output logic              o_src,
   output logic              o_frame_done,
   output logic              o_drop
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LAT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [1:0]        pend, pend_nx;
   logic [1:0]        wd, clr, held, load;
   logic [ADDR_W-1:0] len_rx, len_tx, cur_len;
   logic [ADDR_W-1:0] idx, idx_nx;
   logic              src, src_nx;
   logic              last;
   logic              drop, drop_nx;
   logic [DATA_W-1:0] byte_data;

   // Bit 0 is the RX buffer, bit 1 the TX buffer; zero-length notifications never count.
   always_comb begin
      wd[0]   = i_rx_mem_wdone && (i_rx_mem_byte != '0);
      wd[1]   = i_tx_mem_wdone && (i_tx_mem_byte != '0);
      clr[0]  = (state == S_DONE) && !src;
      clr[1]  = (state == S_DONE) && src;
      // A source finishing this cycle is free again, so a coincident wdone is accepted.
      held    = pend & ~clr;
      load    = wd & ~held;
      pend_nx = held | wd;
      drop_nx = |(wd & held);
   end

   assign cur_len = src ? len_tx : len_rx;

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      src_nx   = src;
      case (state)
         S_IDLE: begin
            if (pend != 2'b00) begin
               state_nx = S_READ;
               idx_nx   = '0;
               src_nx   = (pend == 2'b11) ? ~last : pend[1];
            end
         end
         S_READ: state_nx = S_LAT;
         S_LAT:  state_nx = S_HOLD;
         S_HOLD: begin
            if (i_byte_ready) begin
               if (idx == cur_len - ONE) begin
                  state_nx = S_DONE;
               end else begin
                  state_nx = S_READ;
                  idx_nx   = idx + ONE;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= S_IDLE;
         pend   <= 2'b00;
         len_rx <= '0;
         len_tx <= '0;
         idx    <= '0;
         src    <= 1'b0;
         last   <= 1'b1;
         drop   <= 1'b0;
      end else begin
         state <= state_nx;
         pend  <= pend_nx;
         idx   <= idx_nx;
         src   <= src_nx;
         drop  <= drop_nx;
         if (load[0]) len_rx <= i_rx_mem_byte;
         if (load[1]) len_tx <= i_tx_mem_byte;
         if (state == S_DONE) last <= src;
      end
   end

   // Read data arrives during LAT and is held until the serializer takes it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         byte_data <= '0;
      end else if (state == S_LAT) begin
         byte_data <= src ? i_tx_mem_rdata : i_rx_mem_rdata;
      end
   end

   always_comb begin
      o_rx_mem_ren   = (state == S_READ) && !src;
      o_tx_mem_ren   = (state == S_READ) && src;
      o_rx_mem_raddr = o_rx_mem_ren ? idx : '0;
      o_tx_mem_raddr = o_tx_mem_ren ? idx : '0;
      o_byte_valid   = (state == S_HOLD);
      o_byte_data    = byte_data;
      o_busy         = (state != S_IDLE);
      o_src          = src;
      o_frame_done   = (state == S_DONE);
      o_drop         = drop;
   end

endmodule
